// File: rtl/sft_pkg.sv
// sft_pkg: op codes, sequencer state encoding, command record and the shift-register next-value function
package sft_pkg;
  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_SLL  = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;
  localparam logic [2:0] OP_SRW  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;
  localparam int FIFO_DEPTH = 4;
  localparam int CMD_W      = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic       left;
  } cmd_t;
  function automatic logic [7:0] sft_next(input logic [2:0] op, input logic [7:0] data,
                                          input logic left, input logic [7:0] cur);
    case (op)
      OP_CLR:  return 8'h00;
      OP_LOAD: return data;
      OP_SRL:  return {1'b0, cur[7:1]};
      OP_SLL:  return {cur[6:0], 1'b0};
      OP_SRA:  return {cur[7], cur[7:1]};
      OP_SRW:  return {left, cur[7:1]};
      OP_ROR:  return {cur[0], cur[7:1]};
      default: return {cur[6:0], cur[7]};
    endcase
  endfunction
endpackage

// File: rtl/sft_cmd_fifo.sv
// sft_cmd_fifo: 4-deep command queue; a push into a full queue is taken only alongside a pop
module sft_cmd_fifo import sft_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [CMD_W-1:0] mem_d [FIFO_DEPTH];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full    = cnt_q == 3'(FIFO_DEPTH);
  assign empty   = cnt_q == 3'd0;
  assign dout    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // pointer, occupancy and storage update
  always_comb begin
    mem_d = mem_q;
    wr_d  = push_ok ? wr_q + 2'd1 : wr_q;
    rd_d  = pop_ok ? rd_q + 2'd1 : rd_q;
    cnt_d = cnt_q + {2'b0, push_ok} - {2'b0, pop_ok};
    if (push_ok) mem_d[wr_q] = din;
  end
  // queue state; reset flushes every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sft_seq.sv
// sft_seq: sequences repeated ops onto a hold-less 8-bit shift register and mirrors its contents; SFT_SEQ_FIFO_EN adds a 4-entry command queue
module sft_seq import sft_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_cnt,
  input  logic [7:0] cmd_data,
  input  logic       cmd_left,
  output logic [2:0] sr_op,
  output logic [7:0] sr_in,
  output logic       sr_left,
  output logic [7:0] q,
  output logic       busy,
  output logic       done
);
  state_t state_q, state_d;
  cmd_t cmd_q, cmd_d, head;
  logic [3:0] rem_q, rem_d;
  logic [7:0] q_q, q_d;
  logic done_q, done_d;
  logic take;
`ifdef SFT_SEQ_FIFO_EN
  logic fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  sft_cmd_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (take),
    .din   ({cmd_op, cmd_cnt, cmd_data, cmd_left}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign cmd_ready = !fifo_full;
  assign head      = fifo_dout;
  assign take      = state_q == ST_IDLE && !fifo_empty;
`else
  assign cmd_ready = state_q == ST_IDLE;
  assign head      = {cmd_op, cmd_cnt, cmd_data, cmd_left};
  assign take      = cmd_valid && cmd_ready;
`endif
  assign busy    = state_q == ST_RUN;
  assign done    = done_q;
  assign q       = q_q;
  assign sr_op   = busy ? cmd_q.op : OP_LOAD;
  assign sr_in   = busy ? cmd_q.data : q_q;
  assign sr_left = busy & cmd_q.left;
  // idle holds the register by reloading q; each run cycle applies the latched op and counts down
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (take) begin
        cmd_d   = head;
        rem_d   = (head.op == OP_CLR || head.op == OP_LOAD) ? 4'd1 : head.cnt;
        state_d = rem_d != 4'd0 ? ST_RUN : ST_IDLE;
        done_d  = rem_d == 4'd0;
      end
    end else begin
      q_d     = sft_next(cmd_q.op, cmd_q.data, cmd_q.left, q_q);
      rem_d   = rem_q - 4'd1;
      state_d = rem_q == 4'd1 ? ST_IDLE : ST_RUN;
      done_d  = rem_q == 4'd1;
    end
  end
  // sequencer registers; reset aborts any command without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sft_seq.sv
// tb_sft_seq: directed and random commands against a command-timeline model and an independent shift-register model
module tb_sft_seq;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0, sr_op;
  logic [3:0] cmd_cnt = '0;
  logic [7:0] cmd_data = '0, sr_in, q;
  logic cmd_left = 1'b0, sr_left, busy, done;
  int checks = 0, errors = 0, cyc = 0;
  bit live = 0;
  int m_start = 0, m_len = 0, m_op = 0, m_done_at = -5, m_done_prev = -5;
  logic [7:0] m_q0 = '0, m_data = '0, srm = '0, s_in;
  logic m_left = 1'b0, s_left;
  logic [2:0] s_op;
  int n_busy, n_opc, n_done, n_aft;
  logic [7:0] qb [16];

  sft_seq dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
               .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_left(cmd_left),
               .sr_op(sr_op), .sr_in(sr_in), .sr_left(sr_left), .q(q), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_nxt(input int op, input logic [7:0] d, input logic l, input logic [7:0] c);
    logic [15:0] cc;
    cc = {c, c};
    case (op)
      0: return 8'h00;
      1: return d;
      2: return c >> 1;
      3: return c << 1;
      4: return 8'($signed(c) >>> 1);
      5: return (c >> 1) | (l ? 8'h80 : 8'h00);
      6: return cc[8:1];
      default: return cc[14:7];
    endcase
  endfunction

  function automatic logic [7:0] exp_q(input int c);
    logic [7:0] v;
    int k;
    v = m_q0;
    k = c < m_start ? 0 : (c - m_start > m_len ? m_len : c - m_start);
    for (int i = 0; i < k; i++) v = ref_nxt(m_op, m_data, m_left, v);
    return v;
  endfunction

  task automatic model_reset();
    m_start = 0; m_len = 0; m_q0 = '0; m_done_at = -5; m_done_prev = -5;
  endtask

  // independent shift register following the sr_* drive
  always @(negedge clk) begin
    s_op <= sr_op; s_in <= sr_in; s_left <= sr_left;
  end
  always @(posedge clk or posedge rst) srm <= rst ? 8'h00 : ref_nxt(int'(s_op), s_in, s_left, srm);

  always @(negedge clk) if (!rst && live) chk("q_vs_sr_model", q, srm);

`ifndef SFT_SEQ_FIFO_EN
  // cycle-by-cycle comparison against the command timeline
  always @(negedge clk) begin
    int c;
    bit b;
    logic [7:0] eq;
    if (!rst && live) begin
      c = cyc;
      b = c >= m_start && c < m_start + m_len;
      eq = exp_q(c);
      chk("busy", busy, b);
      chk("done", done, c == m_done_at || c == m_done_prev);
      chk("cmd_ready", cmd_ready, !b);
      chk("sr_op", sr_op, b ? m_op : 1);
      chk("sr_in", sr_in, b ? m_data : eq);
      chk("sr_left", sr_left, b & m_left);
      chk("q", q, eq);
    end
  end
`endif

  task automatic issue(input int op, input int cnt, input logic [7:0] data, input logic left);
    int i;
    @(negedge clk);
    for (i = 0; i < 60 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_cnt = 4'(cnt); cmd_data = data; cmd_left = left;
    m_q0 = exp_q(cyc);
    m_done_prev = m_done_at;
    m_start = cyc + 1;
    m_len = op < 2 ? 1 : cnt;
    m_op = op; m_data = data; m_left = left;
    m_done_at = m_start + m_len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int cnt, input logic [7:0] data, input logic left);
    int i;
    issue(op, cnt, data, left);
    n_busy = 0; n_opc = 0; n_done = 0;
    for (i = 0; i < 40 && n_done == 0; i++) begin
      @(negedge clk);
      if (busy) begin
        qb[n_busy[3:0]] = q;
        n_busy++;
        if (int'(sr_op) == op) n_opc++;
      end
      if (done) n_done++;
    end
    if (n_done == 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    n_aft = int'(done);
  endtask

  initial begin
    int nb, dn, i;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sr_op", sr_op, 1);
    chk("rst_sr_in", sr_in, 8'h00);
    chk("rst_sr_left", sr_left, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    live = 1;

    run_cmd(1, 0, 8'hA5, 1'b0);
    chk("load_a5", q, 8'hA5);
    run_cmd(4, 2, 8'h00, 1'b0);
    chk("sra_busy_cycles", n_busy, 2);
    chk("sra_op4_cycles", n_opc, 2);
    chk("sra_done_once", n_done + n_aft, 1);
    chk("sra_q_mid", qb[1], 8'hD2);
    chk("sra_q_end", q, 8'hE9);

    run_cmd(1, 0, 8'h81, 1'b0);
    run_cmd(7, 1, 8'h00, 1'b0);
    chk("rol_q", q, 8'h03);
    run_cmd(1, 0, 8'h00, 1'b0);
    run_cmd(5, 3, 8'h00, 1'b1);
    chk("srw_q", q, 8'hE0);

    run_cmd(3, 0, 8'h55, 1'b0);
    chk("sll0_busy", n_busy, 0);
    chk("sll0_done", n_done + n_aft, 1);
    chk("sll0_q", q, 8'hE0);

    run_cmd(1, 0, 8'hFF, 1'b0);
    issue(2, 10, 8'h00, 1'b0);
    nb = 0;
    for (i = 0; i < 40 && nb < 3; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("rst_run_reached", nb, 3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sr_op", sr_op, 1);
    chk("abort_sr_in", sr_in, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    for (i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    for (int r = 0; r < 20; r++)
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));

`ifdef SFT_SEQ_FIFO_EN
    begin
      int ops [6] = '{2, 1, 7, 4, 3, 6};
      int cnts [6] = '{15, 0, 1, 2, 0, 3};
      logic [7:0] dat [6] = '{8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
      bit stalled;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (k == 5) begin
          cmd_valid = 1'b0;
          chk("fifo_full_ready", cmd_ready, 0);
        end
        for (i = 0; i < 60 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) chk("fifo_ready_timeout", 0, 1);
        cmd_valid = 1'b1; cmd_op = 3'(ops[k]); cmd_cnt = 4'(cnts[k]); cmd_data = dat[k]; cmd_left = 1'b0;
        @(posedge clk);
      end
      #1 cmd_valid = 1'b0;
      dn = 0;
      stalled = 1;
      for (i = 0; i < 200 && dn < 6; i++) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk("fifo_done_count", dn, 6);
      chk("fifo_order_q", q, 8'hC3);
      stalled = 0;
    end
`endif

    repeat (3) @(negedge clk);
    live = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
